dot_product_accumulator: RTL and testbench
==========================================

# dot_product_accumulator

Downstream consumer of the pipelined 8x8 Vedic multiplier in the matrix multiplier datapath. It tracks operand beats through a valid/last delay line matched to the multiplier's fixed latency and sums the 16-bit products of each row×column vector into one dot-product result. Completed results are buffered in a 2-entry output FIFO with ready/valid handshake. Operand-side flow control guarantees that no in-flight product is ever dropped.

## Interface
- MUL_LATENCY, 6: clock cycles from `a`/`b` presented to the multiplier until the matching `product` is valid; set to the multiplier's pipeline depth (≥1).
- ACC_W, 24: accumulator and result width in bits (≥16).
- CNT_W, 8: beat-count width; maximum vector length is 2^CNT_W−1.

- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair is driven into the multiplier this cycle.
- in_last  input  1  qualifies in_valid; this beat is the final beat of the vector.
- in_ready  output  1  issuer may assert in_valid this cycle.
- product  input  16  multiplier result; sampled only on aligned-valid cycles.
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  consumer accepts the head.
- out_sum  output  ACC_W  dot-product sum at the FIFO head.
- out_count  output  CNT_W  number of beats summed.
- out_ovf  output  1  sum wrapped or count exceeded its maximum for this vector.

## Operation
- Beat issue: accepted beat = in_valid & in_ready. If in_valid is asserted while in_ready=0, the beat is ignored; the issuer must hold its operands.
- Delay line: a MUL_LATENCY-deep shift register carries {valid, last} of each accepted beat. Its output gives d_valid/d_last, which are aligned with `product`.
- Accumulator state: acc[ACC_W], cnt[CNT_W], ovf, first (set = no beat accumulated yet).
- On d_valid: sum = (first ? 0 : acc) + zero-extended product, taken modulo 2^ACC_W. Set ovf on a carry-out of ACC_W. Also set ovf if cnt is already 2^CNT_W−1; cnt then wraps to 0.
- On d_valid & !d_last: acc←sum, cnt←cnt+1, first←0.
- On d_valid & d_last: push {sum, cnt+1, ovf|new_ovf} to the FIFO. Then acc←0, cnt←0, ovf←0, first←1.
- Cycles without d_valid leave the state unchanged. Gaps inside a vector are legal.
- Output FIFO: 2 entries. pop = out_valid & out_ready. Simultaneous push and pop is legal, and the count is unchanged.
- Credit: lasts_in_flight = number of set last bits in the delay line.
  - in_ready = (fifo_count + lasts_in_flight) < 2.
  - This guarantees the FIFO is never pushed while full. Push-while-full is an assertion failure.
- Reset (asynchronous, any time):
  - Delay line, accumulator and FIFO are cleared; a partial vector is discarded.
  - Outputs: out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1 (combinational from the cleared state).

## Timing
- A beat accepted at cycle t has d_valid at t+MUL_LATENCY, and acc updates at the end of that cycle.
- A last beat accepted at t gives out_valid=1 at t+MUL_LATENCY+1 if the FIFO was empty.
- in_ready falls in the same cycle that the second outstanding last is counted, i.e. the cycle after it was accepted.
- in_ready rises combinationally in the cycle after a pop frees a credit.
- out_sum, out_count and out_ovf are stable while out_valid=1 and out_ready=0.
- Throughput: one beat per cycle sustained while the consumer keeps out_ready=1.

## Test plan
- Reset behaviour: assert rst_n=0 mid-stream → all outputs 0 and in_ready=1. After release, a 1-beat vector with product 42 → out_sum=42, out_count=1, out_ovf=0, at MUL_LATENCY+1 cycles after issue.
- 4-beat vector: products 15, 63, 65025, 0 issued back-to-back with out_ready=1 → out_sum=65103, out_count=4, out_ovf=0, with out_valid high for exactly 1 cycle.
- Gaps inside a vector: 3 beats of product 1000 with in_valid idle for 2 cycles between beats → out_sum=3000, out_count=3.
- Backpressure with out_ready=0 and three 2-beat vectors issued:
  - in_ready drops after the second last; the third vector is held.
  - out_valid stays high with the first result stable.
  - After enabling out_ready: all three results arrive in order, none lost.
- Overflow with ACC_W=16: products 65025 and 65025 → out_sum=64514, out_ovf=1. The next vector with product 5 → out_sum=5, out_ovf=0.
- Reset mid-vector: 2 beats in flight, pulse rst_n low, then issue a 1-beat vector with product 7 → the only result seen is out_sum=7, out_count=1.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// Dot-product accumulator behind a fixed-latency multiplier: sums product beats per vector
// and queues completed results in a 2-entry ready/valid FIFO with credit-based issue throttling.
module dot_product_accumulator #(
    parameter int unsigned MUL_LATENCY = 6,
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [15:0]      product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int unsigned LW = $clog2(MUL_LATENCY + 1) + 1;
    localparam int unsigned SW = ACC_W + 1;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } result_t;

    logic [MUL_LATENCY-1:0] r_dv;
    logic [MUL_LATENCY-1:0] r_dl;
    logic [ACC_W-1:0]       r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ovf;
    logic                   r_first;
    result_t                r_mem [2];
    logic                   r_wptr;
    logic                   r_rptr;
    logic [1:0]             r_count;

    logic                   w_accept;
    logic                   w_d_valid;
    logic                   w_d_last;
    logic [LW-1:0]          w_lasts;
    logic [ACC_W-1:0]       w_base;
    logic [SW-1:0]          w_sum_full;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_new_ovf;
    logic                   w_push;
    logic                   w_pop;
    result_t                w_push_data;
    result_t                w_head;

    // Credit counts results already queued plus lasts still travelling the delay line.
    assign w_lasts     = LW'($countones(r_dl));
    assign in_ready    = (LW'(r_count) + w_lasts) < LW'(2);
    assign w_accept    = in_valid & in_ready;

    assign w_d_valid   = r_dv[MUL_LATENCY-1];
    assign w_d_last    = r_dl[MUL_LATENCY-1];
    assign w_base      = r_first ? '0 : r_acc;
    assign w_sum_full  = {1'b0, w_base} + SW'(product);
    assign w_cnt_next  = r_cnt + 1'b1;
    assign w_new_ovf   = w_sum_full[ACC_W] | (&r_cnt);
    assign w_push      = w_d_valid & w_d_last;
    assign w_pop       = out_valid & out_ready;
    assign w_push_data = {w_sum_full[ACC_W-1:0], w_cnt_next, r_ovf | w_new_ovf};

    assign w_head      = r_mem[r_rptr];
    assign out_valid   = (r_count != 2'd0);
    assign out_sum     = w_head.sum;
    assign out_count   = w_head.cnt;
    assign out_ovf     = w_head.ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dv <= '0;
            r_dl <= '0;
        end else begin
            r_dv <= MUL_LATENCY'({r_dv, w_accept});
            r_dl <= MUL_LATENCY'({r_dl, w_accept & in_last});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_first <= 1'b1;
        end else if (w_d_valid) begin
            if (w_d_last) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
                r_first <= 1'b1;
            end else begin
                r_acc   <= w_sum_full[ACC_W-1:0];
                r_cnt   <= w_cnt_next;
                r_ovf   <= r_ovf | w_new_ovf;
                r_first <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_push_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == 2'd2)));

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Randomized and directed bench for dot_product_accumulator: a 24-bit and a 16-bit instance
// share stimulus; results are checked against per-vector arithmetic sums kept by the bench.
module tb_dot_product_accumulator;

    localparam int unsigned L = 6;

    typedef struct packed {
        logic [23:0] s24;
        logic [15:0] s16;
        logic [7:0]  c24;
        logic [7:0]  c16;
        logic        o24;
        logic        o16;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] cur_p = '0;
    logic        out_ready_drv = 1'b1;
    logic        rnd_mode = 1'b0;
    logic        rnd_ready = 1'b1;
    logic        out_ready;
    logic [15:0] product;
    logic [L*16-1:0] pp = '0;

    logic        in_ready, in_ready16, out_valid, out_valid16, out_ovf, out_ovf16;
    logic [23:0] out_sum;
    logic [15:0] out_sum16;
    logic [7:0]  out_count, out_count16;

    int   vecs = 0;
    int   errs = 0;
    int   cyc = 0;
    int   vcyc = 0;
    longint part_sum = 0;
    int   part_n = 0;
    res_t expq[$];
    res_t obsq[$];

    assign out_ready = rnd_mode ? rnd_ready : out_ready_drv;
    assign product   = pp[L*16-1 -: 16];

    dot_product_accumulator #(.MUL_LATENCY(L), .ACC_W(24), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .product(product), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_ovf(out_ovf));

    dot_product_accumulator #(.MUL_LATENCY(L), .ACC_W(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready16),
        .product(product), .out_valid(out_valid16), .out_ready(out_ready), .out_sum(out_sum16),
        .out_count(out_count16), .out_ovf(out_ovf16));

    always #5 clk = ~clk;

    // Behavioural multiplier: the operand's product appears L edges after acceptance; garbage otherwise.
    always @(posedge clk) begin
        pp        <= {pp[(L-1)*16-1:0], (in_valid && in_ready) ? cur_p : 16'($urandom)};
        cyc       <= cyc + 1;
        rnd_ready <= 1'($urandom_range(0, 1));
    end

    // Reference model: whole-vector arithmetic sum, wrap and overflow judged against 2^W.
    always @(negedge clk) begin
        res_t r;
        if (!rst_n) begin
            part_sum = 0;
            part_n   = 0;
            expq.delete();
            obsq.delete();
        end else begin
            if (out_valid) vcyc = vcyc + 1;
            if (in_valid && in_ready) begin
                part_sum = part_sum + longint'(cur_p);
                part_n   = part_n + 1;
                if (in_last) begin
                    r.s24 = 24'(part_sum);
                    r.s16 = 16'(part_sum);
                    r.c24 = 8'(part_n);
                    r.c16 = 8'(part_n);
                    r.o24 = (part_sum >= 64'd16777216) || (part_n > 255);
                    r.o16 = (part_sum >= 64'd65536) || (part_n > 255);
                    expq.push_back(r);
                    part_sum = 0;
                    part_n   = 0;
                end
            end
            if (out_valid && out_ready) begin
                r = {out_sum, out_sum16, out_count, out_count16, out_ovf, out_ovf16};
                obsq.push_back(r);
            end
        end
    end

    task automatic issue(input logic [15:0] p, input logic last);
        bit ok = 0;
        in_valid = 1'b1;
        in_last  = last;
        cur_p    = p;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            errs++;
            $display("FAIL issue_timeout: in_ready stayed 0, required 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        out_ready_drv = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            if (obsq.size() >= expq.size()) begin
                ok = 1;
                break;
            end
        end
        repeat (L + 3) @(posedge clk);
        #1;
        if (!ok) begin
            errs++;
            $display("FAIL drain_timeout: %0d results seen, required %0d", obsq.size(), expq.size());
        end
    endtask

    task automatic test_reset();
        bit seen = 0;
        int c0, lat;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready_drv = 1'b0;
        issue(16'd100, 1'b1);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = out_valid;
        end
        issue(16'd200, 1'b0);
        rst_n = 1'b0;
        #2;
        vecs += 5;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (out_sum !== 24'd0) begin errs++; $display("FAIL rst_out_sum: got %0d want 0", out_sum); end
        if (out_count !== 8'd0) begin errs++; $display("FAIL rst_out_count: got %0d want 0", out_count); end
        if (out_ovf !== 1'b0) begin errs++; $display("FAIL rst_out_ovf: got %b want 0", out_ovf); end
        if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready_drv = 1'b1;
        issue(16'd42, 1'b1);
        c0 = cyc;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - c0;
                break;
            end
        end
        // L edges after the accepting edge is cycle t+L+1 counting the issue cycle as t.
        vecs++;
        if (lat != L) begin errs++; $display("FAIL rst_latency: got %0d edges want %0d", lat, L); end
        drain();
        vecs += 2;
        if (obsq.size() != 1) begin
            errs++; $display("FAIL rst_42_count_results: got %0d want 1", obsq.size());
        end else if (obsq[0] !== res_t'({24'd42, 16'd42, 8'd1, 8'd1, 1'b0, 1'b0})) begin
            errs++; $display("FAIL rst_42_result: got %h want sum 42 count 1 ovf 0", obsq[0]);
        end
        if (expq.size() == 1 && obsq.size() == 1 && obsq[0] !== expq[0]) begin
            errs++; $display("FAIL rst_42_model: got %h want %h", obsq[0], expq[0]);
        end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_back_to_back();
        int v0 = vcyc;
        issue(16'd15, 1'b0);
        issue(16'd63, 1'b0);
        issue(16'd65025, 1'b0);
        issue(16'd0, 1'b1);
        drain();
        vecs += 2;
        if (obsq.size() != 1 || obsq[0] !== res_t'({24'd65103, 16'd65103, 8'd4, 8'd4, 1'b0, 1'b0})) begin
            errs++; $display("FAIL b2b_result: got %0d results, head %h want sum 65103 count 4 ovf 0", obsq.size(), obsq.size() > 0 ? obsq[0] : res_t'(0));
        end
        if (vcyc - v0 != 1) begin errs++; $display("FAIL b2b_valid_cycles: got %0d want 1", vcyc - v0); end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_gaps();
        for (int b = 0; b < 3; b++) begin
            issue(16'd1000, (b == 2) ? 1'b1 : 1'b0);
            if (b != 2) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
        drain();
        vecs++;
        if (obsq.size() != 1 || obsq[0] !== res_t'({24'd3000, 16'd3000, 8'd3, 8'd3, 1'b0, 1'b0})) begin
            errs++; $display("FAIL gaps_result: got %0d results, head %h want sum 3000 count 3", obsq.size(), obsq.size() > 0 ? obsq[0] : res_t'(0));
        end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_backpressure();
        logic [15:0] p [6];
        logic [23:0] want;
        bit stall_bad = 0, hold_bad = 0;
        for (int i = 0; i < 6; i++) p[i] = 16'($urandom);
        out_ready_drv = 1'b0;
        for (int v = 0; v < 2; v++) begin
            issue(p[2*v], 1'b0);
            issue(p[2*v+1], 1'b1);
        end
        vecs++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready_fall: got %b want 0", in_ready); end
        want = 24'(32'(p[0]) + 32'(p[1]));
        in_valid = 1'b1; in_last = 1'b0; cur_p = p[4];
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || in_ready16 !== 1'b0) stall_bad = 1;
            if (k >= L + 2 && (out_valid !== 1'b1 || out_valid16 !== 1'b1 || out_sum !== want || out_count !== 8'd2))
                hold_bad = 1;
        end
        vecs += 2;
        if (stall_bad) begin errs++; $display("FAIL bp_stall: in_ready went high, required 0 while 2 results queued"); end
        if (hold_bad) begin errs++; $display("FAIL bp_hold: head valid=%b sum=%0d count=%0d want 1/%0d/2", out_valid, out_sum, out_count, want); end
        @(posedge clk); #1;
        out_ready_drv = 1'b1;
        issue(p[4], 1'b0);
        issue(p[5], 1'b1);
        drain();
        vecs++;
        if (obsq.size() != 3) begin errs++; $display("FAIL bp_result_count: got %0d want 3", obsq.size()); end
        for (int i = 0; i < obsq.size() && i < 3; i++) begin
            want = 24'(32'(p[2*i]) + 32'(p[2*i+1]));
            vecs++;
            if (obsq[i].s24 !== want || obsq[i].c24 !== 8'd2 || (i < expq.size() && obsq[i] !== expq[i])) begin
                errs++; $display("FAIL bp_result%0d: got %h want sum %0d count 2", i, obsq[i], want);
            end
        end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_overflow();
        issue(16'd65025, 1'b0);
        issue(16'd65025, 1'b1);
        issue(16'd5, 1'b1);
        drain();
        vecs += 2;
        if (obsq.size() < 1 || obsq[0] !== res_t'({24'd130050, 16'd64514, 8'd2, 8'd2, 1'b0, 1'b1})) begin
            errs++; $display("FAIL ovf_wrap: got %h want sum16 64514 ovf16 1 sum24 130050 ovf24 0", obsq.size() > 0 ? obsq[0] : res_t'(0));
        end
        if (obsq.size() != 2 || obsq[1] !== res_t'({24'd5, 16'd5, 8'd1, 8'd1, 1'b0, 1'b0})) begin
            errs++; $display("FAIL ovf_clear: got %0d results, second %h want sum 5 ovf 0", obsq.size(), obsq.size() > 1 ? obsq[1] : res_t'(0));
        end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_reset_mid_vector();
        issue(16'd11, 1'b0);
        issue(16'd22, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(16'd7, 1'b1);
        drain();
        vecs++;
        if (obsq.size() != 1 || obsq[0] !== res_t'({24'd7, 16'd7, 8'd1, 8'd1, 1'b0, 1'b0})) begin
            errs++; $display("FAIL midrst_result: got %0d results, head %h want sum 7 count 1", obsq.size(), obsq.size() > 0 ? obsq[0] : res_t'(0));
        end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_count_wrap();
        for (int n = 255; n <= 256; n++)
            for (int b = 0; b < n; b++) issue(16'($urandom), (b == n - 1) ? 1'b1 : 1'b0);
        drain();
        vecs += 3;
        if (obsq.size() != 2) begin
            errs++; $display("FAIL wrap_result_count: got %0d want 2", obsq.size());
        end else begin
            if (obsq[0].c24 !== 8'd255 || obsq[0].o24 !== 1'b0) begin
                errs++; $display("FAIL wrap_255: got count %0d ovf %b want 255/0", obsq[0].c24, obsq[0].o24);
            end
            if (obsq[1].c24 !== 8'd0 || obsq[1].o24 !== 1'b1 || obsq[1] !== expq[1]) begin
                errs++; $display("FAIL wrap_256: got %h want count 0 ovf 1 (%h)", obsq[1], expq[1]);
            end
        end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_random();
        int len;
        rnd_mode = 1'b1;
        for (int v = 0; v < 40; v++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                issue(($urandom_range(0, 3) == 0) ? 16'd65025 : 16'($urandom), (b == len - 1) ? 1'b1 : 1'b0);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        rnd_mode = 1'b0;
        drain();
        vecs++;
        if (obsq.size() != expq.size()) begin
            errs++; $display("FAIL rnd_result_count: got %0d want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
            vecs++;
            if (obsq[i] !== expq[i]) begin
                errs++; $display("FAIL rnd_result%0d: got %h want %h", i, obsq[i], expq[i]);
            end
        end
        expq.delete(); obsq.delete();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_backpressure();
        test_overflow();
        test_reset_mid_vector();
        test_count_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2 ms, required completion");
        $fatal(1);
    end

endmodule
